cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Top-level control FSM for the multicycle CPU. It adds instruction fetch, PC update, decode, load/store and halt to the existing datapath control (register-file select, A/B/C load enables, ALU operand selects, status load, writeback select). The block sits between the instruction register, program counter, memory interface and datapath, and sequences every instruction from fetch through writeback.

## Interface
Parameters: none. All encodings are fixed in `cpu_pkg`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; the FSM goes to `S_RST` on the next edge.
- `opcode`  in  3  IR[15:13]; stable from the cycle after `load_ir`.
- `op`  in  2  IR[12:11].
- `nsel`  out  2  register-file port select: 00 Rm, 01 Rd, 10 Rn.
- `vsel`  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  A, B, C and status register enables.
- `asel`  out  1  1 forces the ALU A operand to 0.
- `bsel`  out  1  1 selects sximm5 as the ALU B operand.
- `load_ir`  out  1  instruction register enable.
- `load_pc`  out  1  PC enable.
- `reset_pc`  out  1  PC next-value is 0.
- `addr_sel`  out  1  1: memory address is PC; 0: memory address is data-address register.
- `load_addr`  out  1  data-address register enable (captures C[8:0]).
- `mem_cmd`  out  2  00 NONE, 01 READ, 10 WRITE.
- `halted`  out  1  high only in `S_HALT`.

## Operation
- Moore FSM. Outputs are a function of the state, plus `op`/`opcode` in `S_COMP`. Any output not listed for a state is 0; `nsel` and `vsel` default to 00.
- `S_RST`: `reset_pc`=1, `load_pc`=1 → `S_IF1`.
- `S_IF1`: `addr_sel`=1, `mem_cmd`=READ → `S_IF2`.
- `S_IF2`: `addr_sel`=1, `mem_cmd`=READ, `load_ir`=1 → `S_UPC`.
- `S_UPC`: `load_pc`=1 (PC+1) → `S_DEC`.
- `S_DEC` (no outputs) branches on `opcode`/`op`:
  - 110/10 → `S_WIMM`.
  - 110/00 or 101/11 → `S_GETB`.
  - 101/others, 011, 100 → `S_GETA`.
  - 111 → `S_HALT`.
  - any other encoding → `S_IF1` (treated as a NOP).
- `S_WIMM`: `nsel`=Rn, `vsel`=sximm8, `write`=1 → `S_IF1`.
- `S_GETA`: `nsel`=Rn, `loada`=1 → `S_GETB` for opcode 101, otherwise `S_ADDR`.
- `S_GETB`: `nsel`=Rm, `loadb`=1 → `S_COMP`.
- `S_COMP`: `bsel`=0.
  - `asel`=1 for MOV-reg/MVN, else 0.
  - CMP: `loads`=1, `loadc`=0 → `S_IF1`.
  - Otherwise `loadc`=1 → `S_WREG`.
- `S_WREG`: `nsel`=Rd, `vsel`=C, `write`=1 → `S_IF1`.
- `S_ADDR`: `asel`=0, `bsel`=1, `loadc`=1 → `S_LDA`.
- `S_LDA`: `load_addr`=1 → `S_MRD` for LDR, `S_GETD` for STR.
- `S_MRD`: `addr_sel`=0, `mem_cmd`=READ → `S_MWB`.
- `S_MWB`: `addr_sel`=0, `mem_cmd`=READ, `nsel`=Rd, `vsel`=mdata, `write`=1 → `S_IF1`.
- `S_GETD`: `nsel`=Rd, `loadb`=1 → `S_STC`.
- `S_STC`: `asel`=1, `bsel`=0, `loadc`=1 → `S_MWR`.
- `S_MWR`: `addr_sel`=0, `mem_cmd`=WRITE → `S_IF1`.
- `S_HALT`: all outputs 0 except `halted`=1; exits only on `reset`.

## Timing
- `reset` overrides every transition, including mid-instruction and in `S_HALT`. There is no partial writeback: `write` is 0 during the reset cycle's successor `S_RST`.
- Reset output values (state `S_RST`): `reset_pc`=1, `load_pc`=1; all others 0, `mem_cmd`=NONE, `halted`=0.
- Memory read is synchronous with 1-cycle latency. `READ` is held two cycles (`IF1`/`IF2`, `MRD`/`MWB`), and data is consumed in the second cycle.
- Cycles per instruction, counted from `S_IF1` to the next `S_IF1`:
  - MOV imm: 5.
  - MOV reg / MVN: 7.
  - CMP: 7.
  - ADD / AND: 8.
  - LDR: 9.
  - STR: 10.
  - Undefined opcode: 4.
- `write`, `load_*` and `mem_cmd`=WRITE are never asserted in two consecutive cycles by the same instruction.

## Structure
- `cpu_pkg` holds:
  - the state enum `seq_state_t`;
  - opcode constants `OP_MOV`=110, `OP_ALU`=101, `OP_LDR`=011, `OP_STR`=100, `OP_HALT`=111;
  - ALU op constants;
  - `MEM_NONE`, `MEM_READ`, `MEM_WRITE`;
  - `NSEL_*` and `VSEL_*` constants.
- Single module: the state register, next-state logic and output decode stay together. There is no sub-module.

## Test plan
- Reset: `reset`=1 for 2 cycles then 0 → the first cycle shows `reset_pc`=`load_pc`=1; next cycle `S_IF1` with `mem_cmd`=01, `addr_sel`=1.
- MOV imm (opcode 110, op 10) → `load_ir`=1 in `IF2`, `load_pc`=1 in `UPC`, then `write`=1, `nsel`=10, `vsel`=10 on cycle 5; `IF1` again on cycle 6.
- ADD (101/00) and CMP (101/01) → `loada`=1/`nsel`=10, then `loadb`=1/`nsel`=00. ADD then gives `loadc`=1 and `write`=1/`nsel`=01/`vsel`=00. CMP gives `loads`=1 with `loadc`=0 and no `write`.
- LDR (011) → `bsel`=1/`loadc`=1, then `load_addr`=1, then 2 cycles `mem_cmd`=01/`addr_sel`=0 with `write`=1/`vsel`=11 in the second.
- STR (100) → `loadb`=1/`nsel`=01, then `asel`=1/`loadc`=1, then exactly one cycle `mem_cmd`=10/`addr_sel`=0.
- HALT (111), then `reset` asserted mid-ADD at `S_GETB` → `halted`=1 is held for 20 cycles with all enables 0; the mid-ADD reset gives `S_RST` next cycle with no `write`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: sequencer states,
// instruction opcodes, ALU op codes, memory commands and datapath mux selects.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_IF1  = 5'd1,
    S_IF2  = 5'd2,
    S_UPC  = 5'd3,
    S_DEC  = 5'd4,
    S_WIMM = 5'd5,
    S_GETA = 5'd6,
    S_GETB = 5'd7,
    S_COMP = 5'd8,
    S_WREG = 5'd9,
    S_ADDR = 5'd10,
    S_LDA  = 5'd11,
    S_MRD  = 5'd12,
    S_MWB  = 5'd13,
    S_GETD = 5'd14,
    S_STC  = 5'd15,
    S_MWR  = 5'd16,
    S_HALT = 5'd17
  } seq_state_t;

  // Opcodes, IR[15:13]
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // MOV sub-ops, IR[12:11]
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  // ALU sub-ops, IR[12:11]
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Memory commands
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Register-file port select
  localparam logic [1:0] NSEL_RM = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RN = 2'b10;

  // Writeback source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // CMP only updates status; it never produces a C result to write back.
  function automatic logic is_cmp(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OP_ALU) && (op == ALU_CMP);
  endfunction

  // MOV-reg and MVN pass B through the ALU, so the A operand is forced to 0.
  function automatic logic is_zero_a(input logic [2:0] opcode, input logic [1:0] op);
    return ((opcode == OP_MOV) && (op == MOV_REG)) ||
           ((opcode == OP_ALU) && (op == ALU_MVN));
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Top-level Moore control FSM for the multicycle CPU: fetch, PC update,
// decode, register/ALU sequencing, load/store and halt.
//
// state  | meaning
// -------+-----------------------------------------------
// S_RST  | clear PC
// S_IF1  | issue instruction read at PC
// S_IF2  | hold read, capture IR
// S_UPC  | PC <= PC + 1
// S_DEC  | decode opcode/op
// S_WIMM | MOV imm: Rn <= sximm8
// S_GETA | A <= Rn
// S_GETB | B <= Rm
// S_COMP | ALU: C <= result, or status only for CMP
// S_WREG | Rd <= C
// S_ADDR | C <= A + sximm5 (effective address)
// S_LDA  | data-address register <= C[8:0]
// S_MRD  | issue data read
// S_MWB  | hold read, Rd <= mdata
// S_GETD | B <= Rd (store data)
// S_STC  | C <= 0 + B
// S_MWR  | memory write of C
// S_HALT | stopped until reset
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  seq_state_t state;
  seq_state_t state_nxt;

  // State register; reset wins over every transition, including halt.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:  state_nxt = S_IF1;
      S_IF1:  state_nxt = S_IF2;
      S_IF2:  state_nxt = S_UPC;
      S_UPC:  state_nxt = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_MOV: begin
            if (op == MOV_IMM)      state_nxt = S_WIMM;
            else if (op == MOV_REG) state_nxt = S_GETB;
            else                    state_nxt = S_IF1;
          end
          OP_ALU:         state_nxt = (op == ALU_MVN) ? S_GETB : S_GETA;
          OP_LDR, OP_STR: state_nxt = S_GETA;
          OP_HALT:        state_nxt = S_HALT;
          default:        state_nxt = S_IF1;
        endcase
      end
      S_WIMM: state_nxt = S_IF1;
      S_GETA: state_nxt = (opcode == OP_ALU) ? S_GETB : S_ADDR;
      S_GETB: state_nxt = S_COMP;
      S_COMP: state_nxt = is_cmp(opcode, op) ? S_IF1 : S_WREG;
      S_WREG: state_nxt = S_IF1;
      S_ADDR: state_nxt = S_LDA;
      S_LDA:  state_nxt = (opcode == OP_LDR) ? S_MRD : S_GETD;
      S_MRD:  state_nxt = S_MWB;
      S_MWB:  state_nxt = S_IF1;
      S_GETD: state_nxt = S_STC;
      S_STC:  state_nxt = S_MWR;
      S_MWR:  state_nxt = S_IF1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  // Output decode; everything defaults inactive and each state raises its own.
  always_comb begin
    nsel      = NSEL_RM;
    vsel      = VSEL_C;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPC:  load_pc = 1'b1;
      S_WIMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_COMP: begin
        asel = is_zero_a(opcode, op);
        if (is_cmp(opcode, op)) loads = 1'b1;
        else                    loadc = 1'b1;
      end
      S_WREG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LDA:  load_addr = 1'b1;
      S_MRD:  mem_cmd = MEM_READ;
      S_MWB: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = 1'b1;
      end
      S_GETD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_STC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR:  mem_cmd = MEM_WRITE;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [1:0] nsel, vsel, mem_cmd;
  logic write, loada, loadb, loadc, loads, asel, bsel;
  logic load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;

  int tests = 0;
  int fails = 0;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .load_ir(load_ir), .load_pc(load_pc),
    .reset_pc(reset_pc), .addr_sel(addr_sel), .load_addr(load_addr),
    .mem_cmd(mem_cmd), .halted(halted)
  );

  always #5 clk = ~clk;

  // Control word layout:
  // [18:17] nsel [16:15] vsel [14] write [13] loada [12] loadb [11] loadc
  // [10] loads [9] asel [8] bsel [7] load_ir [6] load_pc [5] reset_pc
  // [4] addr_sel [3] load_addr [2:1] mem_cmd [0] halted
  localparam logic [18:0] N_RN = 19'h40000;
  localparam logic [18:0] N_RD = 19'h20000;
  localparam logic [18:0] V_IM = 19'h10000;
  localparam logic [18:0] V_MD = 19'h18000;
  localparam logic [18:0] WR   = 19'h04000;
  localparam logic [18:0] LA   = 19'h02000;
  localparam logic [18:0] LB   = 19'h01000;
  localparam logic [18:0] LC   = 19'h00800;
  localparam logic [18:0] LS   = 19'h00400;
  localparam logic [18:0] AS   = 19'h00200;
  localparam logic [18:0] BS   = 19'h00100;
  localparam logic [18:0] LIR  = 19'h00080;
  localparam logic [18:0] LPC  = 19'h00040;
  localparam logic [18:0] RPC  = 19'h00020;
  localparam logic [18:0] ADS  = 19'h00010;
  localparam logic [18:0] LAD  = 19'h00008;
  localparam logic [18:0] MRD  = 19'h00002;
  localparam logic [18:0] MWR  = 19'h00004;
  localparam logic [18:0] HLT  = 19'h00001;
  localparam logic [18:0] NONE = 19'h00000;

  logic [18:0] obs;
  assign obs = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Check this cycle's control word, then advance one clock.
  task automatic ex(input string tag, input logic [18:0] exp);
    chk(tag, exp);
    tick();
  endtask

  task automatic fetch(input string tag, input logic [2:0] oc, input logic [1:0] o);
    opcode = oc;
    op = o;
    ex({tag, "_if1"}, ADS | MRD);
    ex({tag, "_if2"}, ADS | MRD | LIR);
    ex({tag, "_upc"}, LPC);
    ex({tag, "_dec"}, NONE);
  endtask

  initial begin
    // Reset held two cycles
    reset = 1'b1;
    tick();
    tick();
    chk("rst_state", LPC | RPC);
    reset = 1'b0;
    tick();

    // MOV imm: 5 cycles
    fetch("movi", 3'b110, 2'b10);
    ex("movi_wimm", N_RN | V_IM | WR);

    // MOV reg: 7 cycles, A forced to 0
    fetch("movr", 3'b110, 2'b00);
    ex("movr_getb", LB);
    ex("movr_comp", AS | LC);
    ex("movr_wreg", N_RD | WR);

    // ADD: 8 cycles
    fetch("add", 3'b101, 2'b00);
    ex("add_geta", N_RN | LA);
    ex("add_getb", LB);
    ex("add_comp", LC);
    ex("add_wreg", N_RD | WR);

    // CMP: status only, no writeback
    fetch("cmp", 3'b101, 2'b01);
    ex("cmp_geta", N_RN | LA);
    ex("cmp_getb", LB);
    ex("cmp_comp", LS);

    // AND
    fetch("and", 3'b101, 2'b10);
    ex("and_geta", N_RN | LA);
    ex("and_getb", LB);
    ex("and_comp", LC);
    ex("and_wreg", N_RD | WR);

    // MVN skips GETA
    fetch("mvn", 3'b101, 2'b11);
    ex("mvn_getb", LB);
    ex("mvn_comp", AS | LC);
    ex("mvn_wreg", N_RD | WR);

    // LDR: 9 cycles
    fetch("ldr", 3'b011, 2'b00);
    ex("ldr_geta", N_RN | LA);
    ex("ldr_addr", BS | LC);
    ex("ldr_lda", LAD);
    ex("ldr_mrd", MRD);
    ex("ldr_mwb", MRD | N_RD | V_MD | WR);

    // STR: 10 cycles, one write cycle
    fetch("str", 3'b100, 2'b00);
    ex("str_geta", N_RN | LA);
    ex("str_addr", BS | LC);
    ex("str_lda", LAD);
    ex("str_getd", N_RD | LB);
    ex("str_stc", AS | LC);
    ex("str_mwr", MWR);

    // Undefined encodings fall back to fetch after decode
    fetch("undef0", 3'b000, 2'b00);
    fetch("undef_mov", 3'b110, 2'b01);

    // HALT holds for 20 cycles
    fetch("halt", 3'b111, 2'b00);
    for (int i = 0; i < 20; i++) ex("halt_hold", HLT);

    // Only reset leaves HALT
    reset = 1'b1;
    tick();
    chk("halt_rst", LPC | RPC);
    reset = 1'b0;
    tick();

    // ADD interrupted by reset at GETB
    fetch("add2", 3'b101, 2'b00);
    ex("add2_geta", N_RN | LA);
    chk("add2_getb", LB);
    reset = 1'b1;
    tick();
    chk("midadd_rst", LPC | RPC);
    reset = 1'b0;
    tick();
    chk("post_rst_if1", ADS | MRD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
